seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring unsigned divider; the inverse of the array multiplier. Splits a 2*DW-bit product-width dividend by a DW-bit divisor.
- Sits beside the multiplier in the arithmetic datapath and uses the same i_valid/o_valid convention. Adds i_ready/o_ready because it accepts at most one operation per 2*DW+2 cycles.
- Retires one quotient bit per clock. Output registers hold the result until it is consumed.

Parameters:
- DW, 8, divisor and remainder width; dividend and quotient width is 2*DW.
- CW, $clog2(2*DW+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  2*DW  dividend, unsigned.
- B  input  DW  divisor, unsigned.
- i_valid  input  1  A/B valid.
- i_ready  output  1  divider can accept; high only in IDLE.
- Q  output  2*DW  quotient, registered.
- R  output  DW  remainder, registered.
- div_by_zero  output  1  result was produced with B==0; qualified by o_valid.
- o_valid  output  1  Q/R/div_by_zero valid.
- o_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, immediate): state=IDLE; Q=0, R=0, div_by_zero=0, o_valid=0, i_ready=1; counter and working registers cleared. Reset mid-operation aborts the operation; nothing is emitted afterward.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - i_ready=1, o_valid=0.
  - On i_valid&&i_ready at edge t0: latch A into the dividend shift register and B into the divisor register. Clear partial remainder P (DW+1 bits) and counter. Set dbz_flag=(B==0). Go to BUSY.
- BUSY, dbz_flag=1:
  - At the next edge (t0+1): Q={2*DW{1'b1}}, R=A[DW-1:0], div_by_zero=1. Go to DONE.
- BUSY, normal, per edge:
  - P' = {P[DW-1:0], dividend MSB}; shift dividend left.
  - If P' >= {1'b0,B}: P = P'-B and quotient LSB = 1; else P = P' and quotient LSB = 0.
  - Increment counter.
  - On the 2*DW-th BUSY edge (t0+2*DW): load Q and R=P[DW-1:0], div_by_zero=0, go to DONE.
- Latency: o_valid rises after edge t0+2*DW (normal) or t0+1 (divide by zero).
- DONE:
  - o_valid=1, i_ready=0.
  - Q/R/div_by_zero are held stable while o_ready=0.
  - o_ready=1 at an edge -> IDLE, o_valid=0.
  - No same-cycle accept: i_ready stays 0 in the DONE cycle. Minimum spacing between accepts is 2*DW+2 cycles.
- Inputs: A/B/i_valid are ignored outside IDLE. Changing A/B during BUSY must not affect the result.
- Output registers: Q/R keep the last result after handshake and change only on the next completion or reset.
- Arithmetic:
  - Invariant for B!=0: A == Q*B + R and R < B.
  - Q may exceed 2^DW-1 (e.g. A=65535, B=1); it is full 2*DW width, with no overflow flag.
- Simultaneous events: o_ready asserted before DONE has no effect. i_valid held high across DONE->IDLE is accepted in the IDLE cycle that follows.

Test Plan:
- Reset, then A=16'd65025, B=8'd255, i_valid pulse, o_ready=1 -> o_valid exactly 16 cycles after accept, Q=255, R=0, div_by_zero=0; i_ready low for those 16 cycles plus the DONE cycle.
- A=1000,B=7 -> Q=142,R=6; A=100,B=200 -> Q=0,R=100; A=65535,B=1 -> Q=65535,R=0; A=65535,B=255 -> Q=257,R=0.
- A=16'h0005, B=0 -> o_valid 1 cycle after accept, Q=16'hFFFF, R=8'h05, div_by_zero=1.
- A=1000,B=7 with o_ready=0 for 5 cycles after o_valid -> Q/R/o_valid held stable; handshake on o_ready=1, then i_ready=1 the next cycle. Changing A/B mid-BUSY leaves Q=142,R=6.
- Assert rst at cycle 8 of BUSY -> outputs 0 and i_ready=1 immediately; no o_valid. New op A=50,B=3 -> Q=16,R=2.
- 1000 random back-to-back ops, B!=0, i_valid held high -> scoreboard checks A==Q*B+R and R<B; accepts spaced exactly 2*DW+2 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock, result held in output registers until consumed.
module seq_divider #(
  parameter  int DW = 8,
  localparam int CW = $clog2(2*DW+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] A,
  input  logic [DW-1:0]   B,
  input  logic            i_valid,
  output logic            i_ready,
  output logic [2*DW-1:0] Q,
  output logic [DW-1:0]   R,
  output logic            div_by_zero,
  output logic            o_valid,
  input  logic            o_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [2*DW-1:0] r_dq;       // dividend shifts out the top, quotient bits shift in at the bottom
  logic [DW-1:0]   r_divisor;
  logic [DW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;
  logic            r_dbz;

  logic [2*DW-1:0] r_q;
  logic [DW-1:0]   r_r;
  logic            r_div_by_zero;
  logic            r_o_valid;
  logic            r_i_ready;

  logic [DW:0]     w_p_shift;
  logic [DW:0]     w_sub;
  logic            w_fits;
  logic [DW-1:0]   w_p_next;
  logic [2*DW-1:0] w_dq_next;
  logic            w_last;

  assign w_p_shift = {r_p, r_dq[2*DW-1]};
  assign w_sub     = w_p_shift - {1'b0, r_divisor};
  // The shifted remainder is below 2*B, so a clear MSB after subtracting means no borrow.
  assign w_fits    = ~w_sub[DW];
  assign w_p_next  = w_fits ? w_sub[DW-1:0] : w_p_shift[DW-1:0];
  assign w_dq_next = {r_dq[2*DW-2:0], w_fits};
  assign w_last    = (r_cnt == CW'(2*DW-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dq          <= '0;
      r_divisor     <= '0;
      r_p           <= '0;
      r_cnt         <= '0;
      r_dbz         <= 1'b0;
      r_q           <= '0;
      r_r           <= '0;
      r_div_by_zero <= 1'b0;
      r_o_valid     <= 1'b0;
      r_i_ready     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid && r_i_ready) begin
            r_dq      <= A;
            r_divisor <= B;
            r_p       <= '0;
            r_cnt     <= '0;
            r_dbz     <= (B == '0);
            r_i_ready <= 1'b0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_dbz) begin
            r_q           <= '1;
            r_r           <= r_dq[DW-1:0];
            r_div_by_zero <= 1'b1;
            r_o_valid     <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_p   <= w_p_next;
            r_dq  <= w_dq_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_q           <= w_dq_next;
              r_r           <= w_p_next;
              r_div_by_zero <= 1'b0;
              r_o_valid     <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (o_ready) begin
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_ready     = r_i_ready;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_div_by_zero;
  assign o_valid     = r_o_valid;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, back-pressure, reset abort
// and randomized back-to-back operations checked against a plain-arithmetic model.
module tb_seq_divider;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*DW-1:0] A;
  logic [DW-1:0]   B;
  logic            i_valid;
  logic            i_ready;
  logic [2*DW-1:0] Q;
  logic [DW-1:0]   R;
  logic            div_by_zero;
  logic            o_valid;
  logic            o_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  seq_divider #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .i_valid(i_valid), .i_ready(i_ready),
    .Q(Q), .R(R), .div_by_zero(div_by_zero), .o_valid(o_valid), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Reference: plain integer division; B==0 yields all-ones quotient and A's low byte.
  function automatic logic [3*DW-1:0] ref_div(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] q;
    logic [DW-1:0]   r;
    if (b == 0) begin
      q = '1;
      r = a[DW-1:0];
    end else begin
      q = a / b;
      r = DW'(a % b);
    end
    return {q, r};
  endfunction

  // Runs one operation with o_ready high; reports result, accept-to-o_valid latency
  // and the number of sampled cycles with i_ready low.
  task automatic do_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b,
                       output logic [2*DW-1:0] q, output logic [DW-1:0] r,
                       output logic dbz, output int lat, output int busy);
    int guard = 0;
    while (!i_ready && guard < 100) begin tick(); guard++; end
    A = a; B = b; i_valid = 1'b1; o_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0; busy = 0;
    if (!i_ready) busy++;
    while (!o_valid && lat < 100) begin
      tick(); lat++;
      if (!i_ready) busy++;
    end
    if (!o_valid) lat = -1;
    q = Q; r = R; dbz = div_by_zero;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; A = '0; B = '0; i_valid = 1'b0; o_ready = 1'b0;
    tick(); tick();
    n_tests++;
    if (Q !== 16'd0 || R !== 8'd0 || div_by_zero !== 1'b0 || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: Q=%0d R=%0d dbz=%b o_valid=%b i_ready=%b, want 0 0 0 0 1",
               Q, R, div_by_zero, o_valid, i_ready);
    end
    rst = 1'b0;
    tick();
    $display("[TB] reset: Q=%0d R=%0d o_valid=%b i_ready=%b", Q, R, o_valid, i_ready);
  endtask

  task automatic test_basic();
    logic [2*DW-1:0] q; logic [DW-1:0] r; logic dbz; int lat, busy;
    logic [3*DW-1:0] exp;
    exp = ref_div(16'd65025, 8'd255);
    do_op(16'd65025, 8'd255, q, r, dbz, lat, busy);
    $display("[TB] basic: A=65025 B=255 -> Q=%0d R=%0d dbz=%b lat=%0d busy=%0d", q, r, dbz, lat, busy);
    n_tests++;
    if (lat !== 2*DW) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, 2*DW); end
    n_tests++;
    if ({q, r} !== exp || dbz !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: Q=%0d R=%0d dbz=%b want Q=%0d R=%0d dbz=0", q, r, dbz, exp[3*DW-1:DW], exp[DW-1:0]);
    end
    n_tests++;
    if (busy !== 2*DW+1) begin n_fail++; $display("FAIL basic_i_ready_low: got %0d cycles want %0d", busy, 2*DW+1); end
    n_tests++;
    if (i_ready !== 1'b1) begin n_fail++; $display("FAIL basic_i_ready_back: got %b want 1", i_ready); end
  endtask

  task automatic test_directed();
    logic [2*DW-1:0] ta [4] = '{16'd1000, 16'd100, 16'd65535, 16'd65535};
    logic [DW-1:0]   tb [4] = '{8'd7, 8'd200, 8'd1, 8'd255};
    logic [2*DW-1:0] q; logic [DW-1:0] r; logic dbz; int lat, busy;
    logic [3*DW-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = ref_div(ta[i], tb[i]);
      do_op(ta[i], tb[i], q, r, dbz, lat, busy);
      $display("[TB] directed: A=%0d B=%0d -> Q=%0d R=%0d dbz=%b lat=%0d", ta[i], tb[i], q, r, dbz, lat);
      n_tests++;
      if ({q, r} !== exp || dbz !== 1'b0 || lat !== 2*DW) begin
        n_fail++;
        $display("FAIL directed_%0d: Q=%0d R=%0d dbz=%b lat=%0d want Q=%0d R=%0d dbz=0 lat=%0d",
                 i, q, r, dbz, lat, exp[3*DW-1:DW], exp[DW-1:0], 2*DW);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [2*DW-1:0] q; logic [DW-1:0] r; logic dbz; int lat, busy;
    logic [3*DW-1:0] exp;
    exp = ref_div(16'h0005, 8'd0);
    do_op(16'h0005, 8'd0, q, r, dbz, lat, busy);
    $display("[TB] div_zero: A=5 B=0 -> Q=%h R=%h dbz=%b lat=%0d", q, r, dbz, lat);
    n_tests++;
    if ({q, r} !== exp || dbz !== 1'b1) begin
      n_fail++; $display("FAIL div_zero_result: Q=%h R=%h dbz=%b want Q=%h R=%h dbz=1", q, r, dbz, exp[3*DW-1:DW], exp[DW-1:0]);
    end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL div_zero_latency: got %0d want 1", lat); end
  endtask

  task automatic test_backpressure();
    logic [3*DW-1:0] exp;
    int guard = 0;
    exp = ref_div(16'd1000, 8'd7);
    o_ready = 1'b0;
    while (!i_ready && guard < 100) begin tick(); guard++; end
    A = 16'd1000; B = 8'd7; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick(); tick();
    A = 16'($urandom); B = 8'($urandom);
    guard = 0;
    while (!o_valid && guard < 100) begin tick(); guard++; end
    n_tests++;
    if ({Q, R} !== exp || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_result: Q=%0d R=%0d o_valid=%b want Q=%0d R=%0d o_valid=1", Q, R, o_valid, exp[3*DW-1:DW], exp[DW-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({Q, R} !== exp || o_valid !== 1'b1 || div_by_zero !== 1'b0 || i_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: Q=%0d R=%0d o_valid=%b dbz=%b i_ready=%b want Q=%0d R=%0d 1 0 0",
                 i, Q, R, o_valid, div_by_zero, i_ready, exp[3*DW-1:DW], exp[DW-1:0]);
      end
    end
    o_ready = 1'b1;
    tick();
    $display("[TB] backpressure: A=1000 B=7 -> Q=%0d R=%0d, after handshake o_valid=%b i_ready=%b", Q, R, o_valid, i_ready);
    n_tests++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1 || {Q, R} !== exp) begin
      n_fail++; $display("FAIL bp_handshake: o_valid=%b i_ready=%b Q=%0d R=%0d want 0 1 %0d %0d",
                         o_valid, i_ready, Q, R, exp[3*DW-1:DW], exp[DW-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*DW-1:0] q; logic [DW-1:0] r; logic dbz; int lat, busy;
    logic [3*DW-1:0] exp;
    int seen = 0;
    int guard = 0;
    while (!i_ready && guard < 100) begin tick(); guard++; end
    A = 16'd40000; B = 8'd9; i_valid = 1'b1; o_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (Q !== 16'd0 || R !== 8'd0 || div_by_zero !== 1'b0 || o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: Q=%0d R=%0d dbz=%b o_valid=%b i_ready=%b want 0 0 0 0 1", Q, R, div_by_zero, o_valid, i_ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (o_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_output: o_valid seen %0d cycles want 0", seen); end
    exp = ref_div(16'd50, 8'd3);
    do_op(16'd50, 8'd3, q, r, dbz, lat, busy);
    $display("[TB] reset_mid: then A=50 B=3 -> Q=%0d R=%0d lat=%0d", q, r, lat);
    n_tests++;
    if ({q, r} !== exp || dbz !== 1'b0 || lat !== 2*DW) begin
      n_fail++; $display("FAIL reset_mid_next_op: Q=%0d R=%0d lat=%0d want Q=%0d R=%0d lat=%0d",
                         q, r, lat, exp[3*DW-1:DW], exp[DW-1:0], 2*DW);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] a0; logic [DW-1:0] b0;
    int prev_acc = -1;
    int acc;
    int guard;
    int lhs, rhs;
    i_valid = 1'b1; o_ready = 1'b1;
    A = 16'($urandom); B = 8'($urandom_range(255, 1));
    for (int k = 0; k < 1000; k++) begin
      guard = 0;
      while (!i_ready && guard < 100) begin tick(); guard++; end
      if (!i_ready) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_accept_timeout: op %0d i_ready never rose", k);
        break;
      end
      a0 = A; b0 = B;
      tick();
      acc = cycle;
      if (prev_acc >= 0) begin
        n_tests++;
        if (acc - prev_acc !== 2*DW+2) begin
          n_fail++; $display("FAIL b2b_spacing: op %0d got %0d want %0d", k, acc - prev_acc, 2*DW+2);
        end
      end
      prev_acc = acc;
      A = 16'($urandom); B = 8'($urandom_range(255, 1));
      guard = 0;
      while (!o_valid && guard < 100) begin tick(); guard++; end
      lhs = int'(Q) * int'(b0) + int'(R);
      rhs = int'(a0);
      $display("[TB] b2b %0d: A=%0d B=%0d -> Q=%0d R=%0d dbz=%b", k, a0, b0, Q, R, div_by_zero);
      n_tests++;
      if (o_valid !== 1'b1 || lhs !== rhs || R >= b0 || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_op_%0d: A=%0d B=%0d Q=%0d R=%0d dbz=%b o_valid=%b, want Q*B+R=A with R<B",
                 k, a0, b0, Q, R, div_by_zero, o_valid);
      end
    end
    i_valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_backpressure();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
